// File: rtl/led_fade_pwm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : led_pkg
// Description : Shared widths and constants for the LED fade/PWM output stage.
// Revision    : 1.0
// ============================================================================
package led_pkg;

    localparam int LEVEL_W    = 8;
    localparam int PWM_PERIOD = 255;

    typedef logic [LEVEL_W-1:0] level_t;

    localparam level_t LEVEL_MAX = 8'd255;

endpackage
`default_nettype wire

// File: rtl/led_fade_pwm_channel.sv
`default_nettype none
// ============================================================================
// Module      : led_fade_channel
// Description : One LED channel: saturating up/down brightness level plus the
//               registered PWM comparator.
// Revision    : 1.0
// ============================================================================
module led_fade_channel
    import led_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   enable,
    input  logic   step_tick,
    input  logic   req,
    input  level_t pwm_cnt,
    output level_t level,
    output logic   at_target,
    output logic   pwm
);

    level_t r_level;
    logic   r_pwm;
    level_t w_target;

    // Disabled channels aim for dark so the settled flag reflects the forced state.
    assign w_target  = (enable && req) ? LEVEL_MAX : '0;
    assign at_target = (r_level == w_target);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_level <= '0;
        end else if (!enable) begin
            r_level <= '0;
        end else if (step_tick) begin
            if (r_level < w_target) begin
                r_level <= r_level + LEVEL_W'(1);
            end else if (r_level > w_target) begin
                r_level <= r_level - LEVEL_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pwm <= 1'b0;
        end else begin
            r_pwm <= (r_level > pwm_cnt);
        end
    end

    assign level = r_level;
    assign pwm   = r_pwm;

endmodule
`default_nettype wire

// File: rtl/led_fade_pwm.sv
`default_nettype none
// ============================================================================
// Module      : led_fade_pwm
// Description : Turns on/off LED requests into linear brightness fades rendered
//               as 255-cycle PWM on the LED pins.
// Revision    : 1.0
// ============================================================================
module led_fade_pwm
    import led_pkg::*;
#(
    parameter int N        = 8,
    parameter int STEP_DIV = 25_000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] leds_in,
    input  logic         enable,
    output logic [N-1:0] pwm_out,
    output logic         settled
);

    localparam int                 c_DIV_W    = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(STEP_DIV - 1);
    localparam level_t             c_PWM_LAST = level_t'(PWM_PERIOD - 1);

    logic [N-1:0]         r_req;
    logic [c_DIV_W-1:0]   r_div;
    level_t               r_pwm_cnt;
    logic                 r_settled;
    logic                 w_step_tick;
    logic [N-1:0]         w_at_target;
    // Per-channel levels are exposed for observation only.
    logic [N*LEVEL_W-1:0] w_level_unused;

    // Same-clock source: a single register stage is enough.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_req <= '0;
        end else begin
            r_req <= leds_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div <= '0;
        end else if (!enable || (r_div == c_DIV_LAST)) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + c_DIV_W'(1);
        end
    end

    assign w_step_tick = enable && (r_div == c_DIV_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pwm_cnt <= '0;
        end else if (r_pwm_cnt == c_PWM_LAST) begin
            r_pwm_cnt <= '0;
        end else begin
            r_pwm_cnt <= r_pwm_cnt + LEVEL_W'(1);
        end
    end

    generate
        for (genvar i = 0; i < N; i++) begin : g_ch
            led_fade_channel u_ch (
                .clk       (clk),
                .rst       (rst),
                .enable    (enable),
                .step_tick (w_step_tick),
                .req       (r_req[i]),
                .pwm_cnt   (r_pwm_cnt),
                .level     (w_level_unused[i*LEVEL_W +: LEVEL_W]),
                .at_target (w_at_target[i]),
                .pwm       (pwm_out[i])
            );
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_settled <= 1'b1;
        end else begin
            r_settled <= &w_at_target;
        end
    end

    assign settled = r_settled;

endmodule
`default_nettype wire
